// File: rtl/battleship_pkg.sv
// Shared definitions for the battleship board front end: button indices
// and the per-channel press FSM state type.
package battleship_pkg;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_FIRE  = 4;
  localparam int NUM_BTNS  = 5;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_DELAY        = 2'd1,
    ST_REPEAT       = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } btn_state_t;

endpackage

// File: rtl/button_pulse_gen_if.sv
// Single-cycle button strobe bundle between button_pulse_gen (master)
// and the cursor/game logic (slave).
interface button_pulse_gen_if;

  logic btn_up;
  logic btn_down;
  logic btn_left;
  logic btn_right;
  logic btn_fire;

  modport master (output btn_up, btn_down, btn_left, btn_right, btn_fire);
  modport slave  (input  btn_up, btn_down, btn_left, btn_right, btn_fire);

endinterface

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, debounce counter and press FSM
// producing one-cycle strobes, with optional auto-repeat (REPEAT_ALLOWED).
module btn_channel
  import battleship_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter bit REPEAT_ALLOWED  = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic raw,
  output logic pulse
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic            sync1;
  logic            sync2;
  logic            level;
  logic            rise;
  logic [DB_W-1:0] db_cnt;
  btn_state_t      state;
  logic            rpt_done;

  // NOTE: every register here uses <= so all flops sample the values from
  // before the edge; blocking assignments would chain sync1 straight into
  // sync2 and silently collapse the synchroniser to one stage.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      level  <= 1'b0;
      rise   <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        // The sample completing the stable run flips the level, so the
        // counter never passes DEBOUNCE_CYCLES-1 and cannot wrap.
        level  <= ~level;
        rise   <= ~level;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Disable and release take priority over every state, so a strobe due on
  // the same edge that enable drops or the level falls is never issued.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (!enable) begin
        state <= level ? ST_WAIT_RELEASE : ST_IDLE;
      end else if (!level) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rise) begin
              pulse <= 1'b1;
              state <= REPEAT_ALLOWED ? ST_DELAY : ST_WAIT_RELEASE;
            end
          end
          ST_DELAY: begin
            if (rpt_done) begin
              pulse <= 1'b1;
              state <= ST_REPEAT;
            end
          end
          ST_REPEAT: begin
            if (rpt_done) pulse <= 1'b1;
          end
          ST_WAIT_RELEASE: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  generate
    if (REPEAT_ALLOWED) begin : g_repeat
      localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int RPT_W   = $clog2(RPT_MAX + 1);

      logic [RPT_W-1:0] rpt_cnt;
      logic             load_delay;
      logic             load_period;

      // Mirrors the FSM's pulse conditions so the count restarts on exactly
      // the edges that emit a press or repeat strobe.
      assign load_delay  = enable && level && (state == ST_IDLE) && rise;
      assign load_period = enable && level && rpt_done &&
                           ((state == ST_DELAY) || (state == ST_REPEAT));
      assign rpt_done    = (rpt_cnt == '0);

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          rpt_cnt <= '0;
        end else if (load_delay) begin
          rpt_cnt <= RPT_W'(REPEAT_DELAY - 1);
        end else if (load_period) begin
          rpt_cnt <= RPT_W'(REPEAT_PERIOD - 1);
        end else if (rpt_cnt != '0) begin
          rpt_cnt <= rpt_cnt - 1'b1;
        end
      end
    end else begin : g_no_repeat
      logic unused_rpt_cfg;
      assign unused_rpt_cfg = REPEAT_DELAY[0] ^ REPEAT_PERIOD[0];
      assign rpt_done       = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/button_pulse_gen.sv
// Board push-button front end: five debounced channels driving one-cycle
// strobes. Define BUTTON_AUTO_REPEAT_EN to auto-repeat the direction buttons.
module button_pulse_gen
  import battleship_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      btn_up_raw,
  input  logic                      btn_down_raw,
  input  logic                      btn_left_raw,
  input  logic                      btn_right_raw,
  input  logic                      btn_fire_raw,
  button_pulse_gen_if.master        btns
);

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam bit DIR_REPEAT = 1'b1;
`else
  localparam bit DIR_REPEAT = 1'b0;
`endif

  logic [NUM_BTNS-1:0] raw_vec;
  logic [NUM_BTNS-1:0] strobe_vec;

  assign raw_vec[BTN_UP]    = btn_up_raw;
  assign raw_vec[BTN_DOWN]  = btn_down_raw;
  assign raw_vec[BTN_LEFT]  = btn_left_raw;
  assign raw_vec[BTN_RIGHT] = btn_right_raw;
  assign raw_vec[BTN_FIRE]  = btn_fire_raw;

  generate
    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
      btn_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD),
        .REPEAT_ALLOWED  ((i == BTN_FIRE) ? 1'b0 : DIR_REPEAT)
      ) u_ch (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .raw     (raw_vec[i]),
        .pulse   (strobe_vec[i])
      );
    end
  endgenerate

  assign btns.btn_up    = strobe_vec[BTN_UP];
  assign btns.btn_down  = strobe_vec[BTN_DOWN];
  assign btns.btn_left  = strobe_vec[BTN_LEFT];
  assign btns.btn_right = strobe_vec[BTN_RIGHT];
  assign btns.btn_fire  = strobe_vec[BTN_FIRE];

endmodule

// File: tb/tb_button_pulse_gen.sv
// Directed bench for button_pulse_gen with short timing parameters; offsets
// are edges after E, the first edge that samples the new raw level.
module tb_button_pulse_gen;
  import battleship_pkg::*;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                enable = 1'b0;
  logic [NUM_BTNS-1:0] raw = '0;

  button_pulse_gen_if btns ();

  button_pulse_gen #(
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .btn_up_raw    (raw[BTN_UP]),
    .btn_down_raw  (raw[BTN_DOWN]),
    .btn_left_raw  (raw[BTN_LEFT]),
    .btn_right_raw (raw[BTN_RIGHT]),
    .btn_fire_raw  (raw[BTN_FIRE]),
    .btns          (btns)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;
  int e0 = 0;
  int stray = 0;
  int hits[$];
  int exp_hits[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  function automatic logic [NUM_BTNS-1:0] strobes();
    logic [NUM_BTNS-1:0] s;
    s[BTN_UP]    = btns.btn_up;
    s[BTN_DOWN]  = btns.btn_down;
    s[BTN_LEFT]  = btns.btn_left;
    s[BTN_RIGHT] = btns.btn_right;
    s[BTN_FIRE]  = btns.btn_fire;
    return s;
  endfunction

  function automatic int hit_at(input int i);
    return (i < hits.size()) ? hits[i] : -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  // Advance n edges, logging strobe offsets on channel ch and counting
  // strobes on every other channel.
  task automatic watch(input int n, input int ch);
    logic [NUM_BTNS-1:0] s;
    logic [NUM_BTNS-1:0] others;
    others = '1;
    others[ch] = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      s = strobes();
      if (s[ch]) hits.push_back(edge_n - e0);
      stray += $countones(s & others);
    end
  endtask

  task automatic begin_press(input int ch);
    hits.delete();
    stray = 0;
    raw[ch] = 1'b1;
    e0 = edge_n + 1;
  endtask

  initial begin
    // Reset with inputs quiet.
    repeat (3) tick();
    check("rst_strobes", 32'(strobes()), 0);
    check("rst_state", 32'(dut.g_ch[0].u_ch.state), 32'(ST_IDLE));
    check("rst_level", 32'(dut.g_ch[0].u_ch.level), 0);
    reset_n = 1'b1;
    enable  = 1'b1;
    repeat (4) tick();

    // Clean press of up, 8 cycles.
    begin_press(BTN_UP);
    watch(8, BTN_UP);
    raw[BTN_UP] = 1'b0;
    watch(12, BTN_UP);
    check("up_count", hits.size(), 1);
    check("up_time", hit_at(0), 6);
    check("up_stray", stray, 0);

    // Three-sample glitch on left.
    begin_press(BTN_LEFT);
    watch(3, BTN_LEFT);
    raw[BTN_LEFT] = 1'b0;
    watch(2, BTN_LEFT);
    check("glitch_cnt_peak", 32'(dut.g_ch[2].u_ch.db_cnt), 3);
    watch(1, BTN_LEFT);
    check("glitch_cnt_clear", 32'(dut.g_ch[2].u_ch.db_cnt), 0);
    watch(10, BTN_LEFT);
    check("glitch_count", hits.size(), 0);
    check("glitch_level", 32'(dut.g_ch[2].u_ch.level), 0);
    check("glitch_stray", stray, 0);

    // Right held 38 cycles; last repeat at 41 precedes the release at 44.
    begin_press(BTN_RIGHT);
    watch(38, BTN_RIGHT);
    raw[BTN_RIGHT] = 1'b0;
    watch(20, BTN_RIGHT);
`ifdef BUTTON_AUTO_REPEAT_EN
    exp_hits = '{6, 16, 21, 26, 31, 36, 41};
`else
    exp_hits = '{6};
`endif
    check("right_count", hits.size(), exp_hits.size());
    for (int i = 0; i < exp_hits.size(); i++)
      check($sformatf("right_hit%0d", i), hit_at(i), exp_hits[i]);
    check("right_stray", stray, 0);

    // Fire held 40 cycles never repeats.
    begin_press(BTN_FIRE);
    watch(40, BTN_FIRE);
    raw[BTN_FIRE] = 1'b0;
    watch(15, BTN_FIRE);
    check("fire_count", hits.size(), 1);
    check("fire_time", hit_at(0), 6);
    check("fire_stray", stray, 0);

    // Enable drops on the edge the up strobe would issue.
    begin_press(BTN_UP);
    watch(6, BTN_UP);
    enable = 1'b0;
    watch(4, BTN_UP);
    enable = 1'b1;
    watch(6, BTN_UP);
    raw[BTN_UP] = 1'b0;
    watch(12, BTN_UP);
    check("supp_count", hits.size(), 0);
    check("supp_stray", stray, 0);

    // Down held while disabled, then enabled: silent until re-pressed.
    enable = 1'b0;
    begin_press(BTN_DOWN);
    watch(15, BTN_DOWN);
    enable = 1'b1;
    watch(30, BTN_DOWN);
    raw[BTN_DOWN] = 1'b0;
    watch(12, BTN_DOWN);
    check("held_en_count", hits.size(), 0);
    check("held_en_stray", stray, 0);
    begin_press(BTN_DOWN);
    watch(12, BTN_DOWN);
    raw[BTN_DOWN] = 1'b0;
    watch(12, BTN_DOWN);
    check("repress_count", hits.size(), 1);
    check("repress_time", hit_at(0), 6);

    // Reset for two cycles while up is held (mid-repeat when enabled).
    begin_press(BTN_UP);
    watch(25, BTN_UP);
`ifdef BUTTON_AUTO_REPEAT_EN
    check("prerst_count", hits.size(), 3);
`else
    check("prerst_count", hits.size(), 1);
`endif
    reset_n = 1'b0;
    tick();
    check("inrst_strobes0", 32'(strobes()), 0);
    tick();
    check("inrst_strobes1", 32'(strobes()), 0);
    reset_n = 1'b1;
    hits.delete();
    stray = 0;
    e0 = edge_n + 1;
    watch(12, BTN_UP);
    check("postrst_count", hits.size(), 1);
    check("postrst_time", hit_at(0), 6);
    check("postrst_stray", stray, 0);
    raw[BTN_UP] = 1'b0;
    watch(15, BTN_UP);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
